// File: rtl/wb_initiator_pkg.sv
// Shared types for the Wishbone single-beat initiator: response status codes,
// FSM state encoding and a counter-width helper.
package wb_initiator_pkg;

    typedef enum logic [1:0] {
        STS_OK  = 2'b00,
        STS_ERR = 2'b01,
        STS_RTY = 2'b10,
        STS_TMO = 2'b11
    } rsp_sts_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_e;

    // Width needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 32'd0) ? $clog2(max_val + 32'd1) : 32'd1;
    endfunction

endpackage

// File: rtl/wb_watchdog_cnt.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the
// cycle in which LIMIT enabled cycles have elapsed. LIMIT=0 disables it.
module wb_watchdog_cnt
    import wb_initiator_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned   CW      = cnt_width(LIMIT);
    localparam bit            ENABLED = (LIMIT != 32'd0);
    localparam logic [CW-1:0] LAST    = ENABLED ? CW'(LIMIT - 32'd1) : '0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and saturate at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = ENABLED && en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_single_initiator.sv
// Wishbone pipelined initiator: turns one req pulse into one single-beat WB
// cycle with stall handling, bounded rty re-issue and a watchdog timeout.
module wb_single_initiator
    import wb_initiator_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    req_i,
    input  logic                    req_we_i,
    input  logic [ADDR_WIDTH-1:0]   req_adr_i,
    input  logic [DATA_WIDTH-1:0]   req_dat_i,
    input  logic [DATA_WIDTH/8-1:0] req_sel_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DATA_WIDTH-1:0]   rsp_dat_o,
    output logic [1:0]              rsp_sts_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i,
    input  logic                    wb_stall_i
);

    localparam int unsigned   SW          = DATA_WIDTH / 8;
    localparam int unsigned   RW          = cnt_width(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_e                  state_q,   state_d;
    logic                    cyc_q,     cyc_d;
    logic                    stb_q,     stb_d;
    logic                    we_q,      we_d;
    logic [ADDR_WIDTH-1:0]   adr_q,     adr_d;
    logic [SW-1:0]           sel_q,     sel_d;
    logic [DATA_WIDTH-1:0]   dat_q,     dat_d;
    logic                    busy_q,    busy_d;
    logic                    done_q,    done_d;
    logic [DATA_WIDTH-1:0]   rsp_dat_q, rsp_dat_d;
    rsp_sts_e                rsp_sts_q, rsp_sts_d;
    logic [RW-1:0]           retry_q,   retry_d;

    logic retry_ok_s;
    logic reissue_s;
    logic wd_clr_s;
    logic tmo_s;

    assign retry_ok_s = (retry_q < RETRY_LIMIT);
    // A re-issue only happens when rty is not masked by a simultaneous err.
    assign reissue_s  = (state_q != ST_IDLE) && !wb_err_i && wb_rty_i && retry_ok_s;
    assign wd_clr_s   = (state_q == ST_IDLE) || reissue_s;

    wb_watchdog_cnt #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (wd_clr_s),
        .en_i      (cyc_q),
        .expired_o (tmo_s)
    );

    // Next-state and next-output computation for the transfer FSM.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        sel_d     = sel_q;
        dat_d     = dat_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rsp_dat_d = rsp_dat_q;
        rsp_sts_d = rsp_sts_q;
        retry_d   = retry_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = req_we_i;
                    adr_d   = req_adr_i;
                    dat_d   = req_dat_i;
                    sel_d   = req_sel_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    busy_d  = 1'b1;
                    retry_d = '0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                // Terminations outrank both the timeout and stall acceptance.
                if (wb_err_i || (wb_rty_i && !retry_ok_s) || wb_ack_i || tmo_s) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    if (wb_err_i) begin
                        rsp_sts_d = STS_ERR;
                    end else if (wb_rty_i) begin
                        rsp_sts_d = STS_RTY;
                    end else if (wb_ack_i) begin
                        rsp_sts_d = STS_OK;
                        rsp_dat_d = we_q ? rsp_dat_q : wb_dat_i;
                    end else begin
                        rsp_sts_d = STS_TMO;
                    end
                end else if (wb_rty_i) begin
                    retry_d = retry_q + RW'(1);
                    stb_d   = 1'b1;
                    state_d = ST_ISSUE;
                end else if ((state_q == ST_ISSUE) && !wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = ST_WAIT;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            sel_q     <= '0;
            dat_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rsp_dat_q <= '0;
            rsp_sts_q <= STS_OK;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            dat_q     <= dat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_sts_q <= rsp_sts_d;
            retry_q   <= retry_d;
        end
    end

    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_sel_o  = sel_q;
    assign wb_dat_o  = dat_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rsp_dat_o = rsp_dat_q;
    assign rsp_sts_o = rsp_sts_q;

endmodule

// File: tb/tb_wb_single_initiator.sv
// Directed bench for wb_single_initiator: the bench plays the WB slave
// cycle by cycle and compares outputs against hand-computed values.
module tb_wb_single_initiator;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req_i = 1'b0;
    logic        req_we_i = 1'b0;
    logic [31:0] req_adr_i = 32'd0;
    logic [31:0] req_dat_i = 32'd0;
    logic [3:0]  req_sel_i = 4'd0;
    logic        busy_o, done_o, wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] rsp_dat_o, wb_adr_o, wb_dat_o;
    logic [1:0]  rsp_sts_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = 32'd0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_rty_i = 1'b0;
    logic        wb_stall_i = 1'b0;

    int errors = 0;
    int checks = 0;

    wb_single_initiator #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (8),
        .MAX_RETRY  (3)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .req_i      (req_i),
        .req_we_i   (req_we_i),
        .req_adr_i  (req_adr_i),
        .req_dat_i  (req_dat_i),
        .req_sel_i  (req_sel_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rsp_dat_o  (rsp_dat_o),
        .rsp_sts_o  (rsp_sts_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_rty_i   (wb_rty_i),
        .wb_stall_i (wb_stall_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Present a request for exactly one clock edge.
    task automatic start_req(input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
        req_we_i = we; req_adr_i = adr; req_dat_i = dat; req_sel_i = sel; req_i = 1'b1;
        tick;
        req_i = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o} !== 5'b0) begin errors++;
            $display("FAIL reset_ctl: got %b want 00000", {wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o}); end
        checks++; if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'd0) begin errors++;
            $display("FAIL reset_bus: adr %h dat %h sel %h want 0", wb_adr_o, wb_dat_o, wb_sel_o); end
        checks++; if ({rsp_dat_o, rsp_sts_o} !== 34'd0) begin errors++;
            $display("FAIL reset_rsp: dat %h sts %b want 0", rsp_dat_o, rsp_sts_o); end
        tick; tick;
        rst_n_i = 1'b1;
        tick;
    endtask

    task automatic test_read;
        start_req(1'b0, 32'h0000_0010, 32'd0, 4'hF);
        checks++; if ({wb_cyc_o, wb_stb_o, busy_o, wb_we_o} !== 4'b1110 || wb_adr_o !== 32'h10) begin errors++;
            $display("FAIL rd_issue: cyc/stb/busy/we %b adr %h want 1110 00000010",
                     {wb_cyc_o, wb_stb_o, busy_o, wb_we_o}, wb_adr_o); end
        tick;
        checks++; if ({wb_cyc_o, wb_stb_o, done_o} !== 3'b100) begin errors++;
            $display("FAIL rd_wait: cyc/stb/done %b want 100", {wb_cyc_o, wb_stb_o, done_o}); end
        wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
        tick;
        wb_ack_i = 1'b0;
        checks++; if ({done_o, wb_cyc_o, busy_o} !== 3'b100) begin errors++;
            $display("FAIL rd_done_lat3: done/cyc/busy %b want 100", {done_o, wb_cyc_o, busy_o}); end
        checks++; if (rsp_dat_o !== 32'hCAFE_F00D || rsp_sts_o !== 2'b00) begin errors++;
            $display("FAIL rd_rsp: dat %h sts %b want cafef00d 00", rsp_dat_o, rsp_sts_o); end
        tick;
        checks++; if (done_o !== 1'b0) begin errors++;
            $display("FAIL rd_done_pulse: got %b want 0", done_o); end
    endtask

    task automatic test_stall_write;
        int stb_cycles = 0;
        bit unstable = 1'b0;
        wb_stall_i = 1'b1;
        start_req(1'b1, 32'h4000_0004, 32'h1234_5678, 4'b0011);
        for (int c = 0; c < 5; c++) begin
            if (c == 4) wb_stall_i = 1'b0;
            if (wb_stb_o) stb_cycles++;
            if (wb_adr_o !== 32'h4000_0004 || wb_dat_o !== 32'h1234_5678 ||
                wb_sel_o !== 4'b0011 || wb_we_o !== 1'b1) unstable = 1'b1;
            tick;
        end
        checks++; if (stb_cycles != 5) begin errors++;
            $display("FAIL wr_stall_stb: got %0d cycles want 5", stb_cycles); end
        checks++; if (unstable) begin errors++;
            $display("FAIL wr_stall_bus: got unstable adr/dat/sel want stable"); end
        checks++; if ({wb_stb_o, wb_cyc_o} !== 2'b01) begin errors++;
            $display("FAIL wr_accept: stb/cyc %b want 01", {wb_stb_o, wb_cyc_o}); end
        wb_ack_i = 1'b1; wb_dat_i = 32'hBAD0_BAD0;
        tick;
        wb_ack_i = 1'b0;
        checks++; if (done_o !== 1'b1 || rsp_sts_o !== 2'b00 || rsp_dat_o !== 32'hCAFE_F00D) begin errors++;
            $display("FAIL wr_done: done %b sts %b dat %h want 1 00 cafef00d", done_o, rsp_sts_o, rsp_dat_o); end
        tick;
    endtask

    task automatic test_retry(input int n_rty, input logic [1:0] exp_sts, input logic [31:0] exp_dat);
        int stb_cycles = 0;
        int resp = 0;
        bit pend = 1'b0;
        bit gap = 1'b0;
        bit got_done = 1'b0;
        start_req(1'b0, 32'h0000_0020, 32'd0, 4'hF);
        for (int c = 0; c < 40; c++) begin
            if (done_o) begin
                got_done = 1'b1;
                break;
            end
            if (!wb_cyc_o) gap = 1'b1;
            wb_rty_i = 1'b0; wb_ack_i = 1'b0;
            if (pend) begin
                if (resp < n_rty) wb_rty_i = 1'b1;
                else begin wb_ack_i = 1'b1; wb_dat_i = 32'hA5A5_0003; end
                resp++;
                pend = 1'b0;
            end
            if (wb_stb_o) begin stb_cycles++; pend = 1'b1; end
            tick;
        end
        wb_rty_i = 1'b0; wb_ack_i = 1'b0;
        checks++; if (!got_done) begin errors++;
            $display("FAIL rty%0d_done: got no done within 40 cycles want done", n_rty); end
        checks++; if (stb_cycles != 4 || resp != 4 || gap) begin errors++;
            $display("FAIL rty%0d_pulses: stb %0d resp %0d gap %0b want 4 4 0", n_rty, stb_cycles, resp, gap); end
        checks++; if (rsp_sts_o !== exp_sts || rsp_dat_o !== exp_dat) begin errors++;
            $display("FAIL rty%0d_rsp: sts %b dat %h want %b %h", n_rty, rsp_sts_o, rsp_dat_o, exp_sts, exp_dat); end
        tick;
    endtask

    task automatic test_timeout;
        int cyc_cycles = 0;
        start_req(1'b0, 32'h0000_0030, 32'd0, 4'hF);
        while (wb_cyc_o && cyc_cycles < 20) begin
            cyc_cycles++;
            tick;
        end
        checks++; if (cyc_cycles != 8) begin errors++;
            $display("FAIL tmo_len: got %0d cyc cycles want 8", cyc_cycles); end
        checks++; if (done_o !== 1'b1 || rsp_sts_o !== 2'b11 || rsp_dat_o !== 32'hA5A5_0003) begin errors++;
            $display("FAIL tmo_rsp: done %b sts %b dat %h want 1 11 a5a50003", done_o, rsp_sts_o, rsp_dat_o); end
        tick;
    endtask

    task automatic test_err_ack;
        wb_ack_i = 1'b1; wb_err_i = 1'b1;
        tick;
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        checks++; if ({done_o, busy_o, wb_cyc_o} !== 3'b000 || rsp_sts_o !== 2'b11) begin errors++;
            $display("FAIL idle_term_ignored: done/busy/cyc %b sts %b want 000 11",
                     {done_o, busy_o, wb_cyc_o}, rsp_sts_o); end
        start_req(1'b0, 32'h0000_0040, 32'd0, 4'hF);
        tick;
        wb_err_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        tick;
        wb_err_i = 1'b0; wb_ack_i = 1'b0;
        checks++; if (done_o !== 1'b1 || rsp_sts_o !== 2'b01 || rsp_dat_o !== 32'hA5A5_0003) begin errors++;
            $display("FAIL err_prio: done %b sts %b dat %h want 1 01 a5a50003", done_o, rsp_sts_o, rsp_dat_o); end
        tick;
    endtask

    task automatic test_busy_ignore;
        bit adr_moved = 1'b0;
        req_we_i = 1'b1; req_adr_i = 32'h0000_0050; req_dat_i = 32'h0F0F_0F0F; req_sel_i = 4'hF;
        req_i = 1'b1;
        tick;
        req_adr_i = 32'h0000_0060; wb_stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) wb_stall_i = 1'b0;
            if (wb_adr_o !== 32'h0000_0050) adr_moved = 1'b1;
            tick;
        end
        req_i = 1'b0;
        wb_ack_i = 1'b1;
        tick;
        wb_ack_i = 1'b0;
        checks++; if (adr_moved || done_o !== 1'b1 || wb_adr_o !== 32'h0000_0050) begin errors++;
            $display("FAIL busy_req: moved %0b done %b adr %h want 0 1 00000050", adr_moved, done_o, wb_adr_o); end
        tick;
        checks++; if ({wb_cyc_o, busy_o} !== 2'b00) begin errors++;
            $display("FAIL busy_not_queued: cyc/busy %b want 00", {wb_cyc_o, busy_o}); end
    endtask

    task automatic test_back_to_back;
        start_req(1'b0, 32'h0000_0070, 32'd0, 4'hF);
        tick;
        wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0011;
        tick;
        wb_ack_i = 1'b0;
        checks++; if (done_o !== 1'b1 || rsp_dat_o !== 32'h0000_0011) begin errors++;
            $display("FAIL b2b_first: done %b dat %h want 1 00000011", done_o, rsp_dat_o); end
        start_req(1'b0, 32'h0000_0074, 32'd0, 4'hF);
        checks++; if ({wb_cyc_o, wb_stb_o, done_o} !== 3'b110 || wb_adr_o !== 32'h0000_0074) begin errors++;
            $display("FAIL b2b_accept: cyc/stb/done %b adr %h want 110 00000074",
                     {wb_cyc_o, wb_stb_o, done_o}, wb_adr_o); end
        tick;
        wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0022;
        tick;
        wb_ack_i = 1'b0;
        checks++; if (done_o !== 1'b1 || rsp_dat_o !== 32'h0000_0022 || rsp_sts_o !== 2'b00) begin errors++;
            $display("FAIL b2b_second: done %b dat %h sts %b want 1 00000022 00", done_o, rsp_dat_o, rsp_sts_o); end
        tick;
    endtask

    task automatic test_reset_mid;
        bit saw_done = 1'b0;
        start_req(1'b0, 32'h0000_0080, 32'd0, 4'hF);
        tick;
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++; if ({wb_cyc_o, wb_stb_o, busy_o, done_o} !== 4'b0000) begin errors++;
            $display("FAIL rst_async: cyc/stb/busy/done %b want 0000", {wb_cyc_o, wb_stb_o, busy_o, done_o}); end
        tick;
        rst_n_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (done_o) saw_done = 1'b1;
            tick;
        end
        checks++; if (saw_done) begin errors++;
            $display("FAIL rst_no_done: got done pulse want none"); end
        start_req(1'b0, 32'h0000_0084, 32'd0, 4'hF);
        tick;
        wb_ack_i = 1'b1; wb_dat_i = 32'h0000_5A5A;
        tick;
        wb_ack_i = 1'b0;
        checks++; if (done_o !== 1'b1 || rsp_dat_o !== 32'h0000_5A5A || rsp_sts_o !== 2'b00) begin errors++;
            $display("FAIL rst_recover: done %b dat %h sts %b want 1 00005a5a 00", done_o, rsp_dat_o, rsp_sts_o); end
        tick;
    endtask

    initial begin
        test_reset;
        test_read;
        test_stall_write;
        test_retry(3, 2'b00, 32'hA5A5_0003);
        test_retry(4, 2'b10, 32'hA5A5_0003);
        test_timeout;
        test_err_ack;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
